neuron_sequencer: RTL
=====================

Name: neuron_sequencer

Overview:
- Per-core control FSM that drives the neuron_block datapath for one tick.
- On start, walks neurons 0..NUM_NEURONS-1. For each neuron it:
  - reads the synapse row and the stored potential;
  - loads the potential into the integrator;
  - scans every axon and issues one integrate per active connected axon;
  - writes back the post-leak/threshold potential;
  - emits any spike through a valid/ready handshake.
- Sits between the core's synapse/potential memories, the axon spike buffer and neuron_block.

Parameters:
- NUM_AXONS, 256, axons per core (scan length).
- NUM_NEURONS, 256, neurons per core.
- NUM_WEIGHTS, 4, axon types; width of neuron_instruction is $clog2(NUM_WEIGHTS).

Ports:
- clk  in  1  core clock; all state on rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  tick pulse; accepted only in IDLE.
- axon_spikes  in  NUM_AXONS  spike flag per axon; latched on accepted start.
- axon_types  in  NUM_AXONS*$clog2(NUM_WEIGHTS)  type of axon a at bits [a*T +: T]; stable while busy.
- syn_rd_en  out  1  synapse row read strobe.
- syn_rd_addr  out  $clog2(NUM_NEURONS)  row index (= neuron).
- syn_rd_data  in  NUM_AXONS  connection bits; valid one cycle after syn_rd_en.
- pot_rd_en  out  1  potential read strobe; same timing as syn_rd_en.
- pot_wr_en  out  1  potential write strobe (data comes from neuron_block write_potential).
- pot_addr  out  $clog2(NUM_NEURONS)  neuron index, shared by read and write.
- neuron_instruction  out  $clog2(NUM_WEIGHTS)  weight select to neuron_block.
- next_neuron  out  1  integrator loads current_potential.
- integrator_reg_en  out  1  integrator register enable.
- write_current_potential  out  1  forces zero weight during load.
- spike_in  in  1  neuron_block spike_out.
- spike_valid  out  1  spike available.
- spike_neuron  out  $clog2(NUM_NEURONS)  index of spiking neuron.
- spike_ready  in  1  downstream accepts spike.
- busy  out  1  high from start acceptance until DONE exits.
- done  out  1  one-cycle pulse at end of tick.

Behaviour:
- Reset (rst=0, async): state IDLE. All outputs 0; neuron counter n=0, axon counter a=0; latched spike vector and row register cleared.
- IDLE: start=1 latches axon_spikes, sets n=0, busy=1 from the next cycle, goes to READ. start in any other state is ignored.
- READ (1 cycle): syn_rd_en=pot_rd_en=1, syn_rd_addr=pot_addr=n. Goes to LOAD.
- LOAD (1 cycle):
  - Registers syn_rd_data into the row register.
  - Drives next_neuron=1, integrator_reg_en=1, write_current_potential=1, so the integrator captures the memory read data.
  - Sets a=0 and goes to INTEG.
- INTEG (exactly NUM_AXONS cycles, a=0..NUM_AXONS-1):
  - next_neuron=0, write_current_potential=0.
  - integrator_reg_en = latched_spike[a] & row[a].
  - neuron_instruction = axon_types[a]; driven every cycle, don't-care when enable is 0.
  - a wraps after NUM_AXONS-1, then goes to WRITE.
- WRITE (1 cycle):
  - pot_wr_en=1, pot_addr=n; integrator_reg_en=0.
  - Samples spike_in. If spike_in=1: spike_valid=1, spike_neuron=n from the next cycle, and goes to SPIKE.
  - Otherwise goes to ADV.
- SPIKE: holds spike_valid and spike_neuron stable until the cycle spike_ready=1. On that handshake it drops spike_valid the next cycle and goes to ADV. No other output is active while stalled.
- ADV:
  - Combinational decision, no extra cycle; applied at exit of WRITE/SPIKE.
  - If n==NUM_NEURONS-1 → DONE. Otherwise n<=n+1 → READ.
- DONE (1 cycle): done=1, busy drops to 0 the next cycle, returns to IDLE.
- Latency per neuron without stall: NUM_AXONS+3 cycles. Full tick: NUM_NEURONS*(NUM_AXONS+3)+1 cycles plus spike stall cycles.
- Simultaneous events:
  - spike_ready high when no spike is valid has no effect.
  - start in the DONE cycle is ignored.
- Reset mid-tick aborts immediately:
  - No pot_wr_en for the interrupted neuron.
  - Any pending spike is discarded.
  - done is not pulsed.

Test Plan:
- NUM_AXONS=4, NUM_NEURONS=2; spikes=4'b1011; row0=4'b0011; types a0=2, a1=1; potential 5; weights {w0=1, w1=2, w2=3, w3=4}; leak 0; threshold 20 → integrator_reg_en only at a=0 (instr 2) and a=1 (instr 1); write_potential=10; no spike_valid; per-neuron latency 7 cycles.
- Same setup, threshold 8 → spike_valid=1, spike_neuron=0; spike_ready held low 5 cycles → outputs stable, no neuron 1 READ until handshake; then neuron 1 proceeds.
- All-zero spikes → integrator_reg_en never asserted in INTEG; pot_wr_en once per neuron; done pulses at cycle 2*7+1 after start.
- start pulsed during INTEG → ignored: n unchanged, single done at end.
- rst=0 asserted during INTEG of neuron 1 → outputs 0 asynchronously; no write for neuron 1; no done; a later start runs a full tick from neuron 0.
- Spikes on both neurons with spike_ready tied 1 → two single-cycle spike_valid pulses, indices 0 then 1.

Source files
------------

// File: rtl/neuron_sequencer.sv
// neuron_sequencer
//   Per-core control FSM for one tick of the neuron_block datapath. On an
//   accepted start it walks neurons 0..NUM_NEURONS-1. Each neuron goes through
//   READ, LOAD, then NUM_AXONS INTEG cycles, then WRITE. A neuron that spikes
//   also stalls in SPIKE until its spike is handed off. DONE ends the tick.
//
// Ports
//   clk, rst                 clock; asynchronous active-low reset
//   start                    tick request, honoured only in IDLE
//   axon_spikes              per-axon spike flags, latched on accepted start
//   axon_types               per-axon weight type, T bits per axon
//   syn_rd_en/addr/data      synapse row read (data one cycle after en)
//   pot_rd_en/pot_wr_en      potential memory strobes, address pot_addr
//   neuron_instruction       weight select for neuron_block
//   next_neuron, integrator_reg_en, write_current_potential
//                            integrator controls
//   spike_in                 neuron_block spike flag, sampled in WRITE
//   spike_valid/neuron/ready spike output handshake
//   busy, done               tick status
//   state_dbg                current FSM state (debug observation)
//
// Spike handshake: spike_valid and spike_neuron are registered and held
// stable while spike_valid=1 and spike_ready=0. A transfer happens on the
// rising edge where both are 1, and spike_valid drops after that edge.
// spike_ready is ignored while spike_valid=0.

module neuron_sequencer #(
    parameter int NUM_AXONS   = 256,
    parameter int NUM_NEURONS = 256,
    parameter int NUM_WEIGHTS = 4
) (
    input  logic                                       clk,
    input  logic                                       rst,
    input  logic                                       start,
    input  logic [NUM_AXONS-1:0]                       axon_spikes,
    input  logic [NUM_AXONS*$clog2(NUM_WEIGHTS)-1:0]   axon_types,
    output logic                                       syn_rd_en,
    output logic [$clog2(NUM_NEURONS)-1:0]             syn_rd_addr,
    input  logic [NUM_AXONS-1:0]                       syn_rd_data,
    output logic                                       pot_rd_en,
    output logic                                       pot_wr_en,
    output logic [$clog2(NUM_NEURONS)-1:0]             pot_addr,
    output logic [$clog2(NUM_WEIGHTS)-1:0]             neuron_instruction,
    output logic                                       next_neuron,
    output logic                                       integrator_reg_en,
    output logic                                       write_current_potential,
    input  logic                                       spike_in,
    output logic                                       spike_valid,
    output logic [$clog2(NUM_NEURONS)-1:0]             spike_neuron,
    input  logic                                       spike_ready,
    output logic                                       busy,
    output logic                                       done,
    output logic [2:0]                                 state_dbg
);

    localparam int TW = $clog2(NUM_WEIGHTS);
    localparam int NW = $clog2(NUM_NEURONS);
    localparam int AW = (NUM_AXONS > 1) ? $clog2(NUM_AXONS) : 1;

    localparam logic [AW-1:0] LAST_AXON   = AW'(NUM_AXONS - 1);
    localparam logic [NW-1:0] LAST_NEURON = NW'(NUM_NEURONS - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_READ  = 3'd1,
        S_LOAD  = 3'd2,
        S_INTEG = 3'd3,
        S_WRITE = 3'd4,
        S_SPIKE = 3'd5,
        S_DONE  = 3'd6
    } state_t;

    state_t                state, state_next;
    logic [NW-1:0]         n;
    logic [AW-1:0]         a;
    logic [NUM_AXONS-1:0]  spk_lat;
    logic [NUM_AXONS-1:0]  row;
    logic                  last_neuron;
    logic                  last_axon;

    assign last_neuron = (n == LAST_NEURON);
    assign last_axon   = (a == LAST_AXON);
    assign state_dbg   = state;

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state and combinational outputs
    always_comb begin
        state_next              = state;
        syn_rd_en               = 1'b0;
        syn_rd_addr             = '0;
        pot_rd_en               = 1'b0;
        pot_wr_en               = 1'b0;
        pot_addr                = '0;
        neuron_instruction      = '0;
        next_neuron             = 1'b0;
        integrator_reg_en       = 1'b0;
        write_current_potential = 1'b0;
        done                    = 1'b0;

        case (state)
            S_IDLE: begin
                if (start) state_next = S_READ;
            end
            S_READ: begin
                syn_rd_en   = 1'b1;
                pot_rd_en   = 1'b1;
                syn_rd_addr = n;
                pot_addr    = n;
                state_next  = S_LOAD;
            end
            S_LOAD: begin
                // Weight forced to zero so the integrator just captures the
                // stored potential arriving from memory this cycle.
                next_neuron             = 1'b1;
                integrator_reg_en       = 1'b1;
                write_current_potential = 1'b1;
                state_next              = S_INTEG;
            end
            S_INTEG: begin
                integrator_reg_en  = spk_lat[a] & row[a];
                neuron_instruction = axon_types[int'(a)*TW +: TW];
                if (last_axon) state_next = S_WRITE;
            end
            S_WRITE: begin
                pot_wr_en = 1'b1;
                pot_addr  = n;
                if (spike_in)         state_next = S_SPIKE;
                else if (last_neuron) state_next = S_DONE;
                else                  state_next = S_READ;
            end
            S_SPIKE: begin
                if (spike_ready) state_next = last_neuron ? S_DONE : S_READ;
            end
            S_DONE: begin
                done       = 1'b1;
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Counters, latched operands and registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            n            <= '0;
            a            <= '0;
            spk_lat      <= '0;
            row          <= '0;
            busy         <= 1'b0;
            spike_valid  <= 1'b0;
            spike_neuron <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        spk_lat <= axon_spikes;
                        n       <= '0;
                        busy    <= 1'b1;
                    end
                end
                S_LOAD: begin
                    row <= syn_rd_data;
                    a   <= '0;
                end
                S_INTEG: begin
                    a <= last_axon ? '0 : a + 1'b1;
                end
                S_WRITE: begin
                    if (spike_in) begin
                        spike_valid  <= 1'b1;
                        spike_neuron <= n;
                    end else if (!last_neuron) begin
                        n <= n + 1'b1;
                    end
                end
                S_SPIKE: begin
                    if (spike_ready) begin
                        spike_valid <= 1'b0;
                        if (!last_neuron) n <= n + 1'b1;
                    end
                end
                S_DONE: begin
                    busy <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule
